// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner
// Receives a pair of asynchronous active-low set/reset contacts. Each input
// goes through a 2-flop synchroniser and a per-input debounce filter. The
// filtered pair then drives a registered model of a NAND set/reset latch.
// That latch model produces one-cycle set/reset strobes and a level flag
// while both inputs are asserted.
// No valid/ready handshake exists on this block: the inputs are levels and
// the outputs are levels or single-cycle strobes in the clk domain.

module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_n,
  input  logic r_n,
  output logic q,
  output logic qbar,
  output logic set_pulse,
  output logic reset_pulse,
  output logic illegal
);

  // Latch states. FORBID is the both-asserted condition of a NAND latch.
  typedef enum logic [1:0] {
    HOLD0  = 2'd0,
    HOLD1  = 2'd1,
    FORBID = 2'd2
  } state_t;

  // The counter tops out at DEBOUNCE_CYCLES-1 and then clears. With the
  // legal parameter range it therefore never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s_meta, s_sync, r_meta, r_sync;
  logic             s_f, r_f;
  logic [CNT_W-1:0] s_cnt, r_cnt;
  state_t           state;
  state_t           state_nxt;

  // Latch transition rules on the filtered (active-low) pair.
  // Both released while in FORBID resolves deterministically to HOLD0.
  function automatic state_t next_state(input state_t cur, input logic sf, input logic rf);
    state_t nxt;
    nxt = cur;
    case (cur)
      HOLD0: begin
        if (!sf && rf)       nxt = HOLD1;
        else if (!sf && !rf) nxt = FORBID;
      end
      HOLD1: begin
        if (sf && !rf)       nxt = HOLD0;
        else if (!sf && !rf) nxt = FORBID;
      end
      FORBID: begin
        if (!sf && rf)       nxt = HOLD1;
        else if (sf)         nxt = HOLD0;
      end
      default:               nxt = HOLD0;
    endcase
    return nxt;
  endfunction

  // Two-flop synchronisers. They reset to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      s_meta <= s_n;
      s_sync <= s_meta;
      r_meta <= r_n;
      r_sync <= r_meta;
    end
  end

  // Set-input debounce: s_f follows the synchronised s_n only after
  // DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_f   <= 1'b1;
      s_cnt <= '0;
    end else if (s_sync == s_f) begin
      s_cnt <= '0;
    end else if (s_cnt == CNT_LAST) begin
      s_f   <= s_sync;
      s_cnt <= '0;
    end else begin
      s_cnt <= s_cnt + CNT_ONE;
    end
  end

  // Reset-input debounce. The structure is identical to the set path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f   <= 1'b1;
      r_cnt <= '0;
    end else if (r_sync == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_f   <= r_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Next latch state from the current state and the filtered pair.
  always_comb begin
    state_nxt = next_state(state, s_f, r_f);
  end

  // Latch state plus all registered outputs. The outputs are decoded from
  // the next state so that they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD0;
      q           <= 1'b0;
      qbar        <= 1'b1;
      set_pulse   <= 1'b0;
      reset_pulse <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_nxt;
      q           <= (state_nxt != HOLD0);
      qbar        <= (state_nxt != HOLD1);
      illegal     <= (state_nxt == FORBID);
      set_pulse   <= (state_nxt == HOLD1) && (state != HOLD1);
      reset_pulse <= (state_nxt == HOLD0) && (state != HOLD0);
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Testbench for sr_input_conditioner.
// A behavioural model keeps the history of sampled inputs. A filtered level
// flips once the last DEBOUNCE_CYCLES synchronised samples all disagree with
// it. The latch follows set/reset/forbid rules. One process compares every
// output against the model on each falling edge. Directed steps pin the
// model with literal values, and a random phase follows.

module tb_sr_input_conditioner;

  localparam int D     = 4;
  localparam int CNT_W = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s_n   = 1'b1;
  logic r_n   = 1'b1;
  logic q, qbar, set_pulse, reset_pulse, illegal;

  always #5 clk = ~clk;

  sr_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_n        (s_n),
    .r_n        (r_n),
    .q          (q),
    .qbar       (qbar),
    .set_pulse  (set_pulse),
    .reset_pulse(reset_pulse),
    .illegal    (illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Latch mode: 0 = holding 0, 1 = holding 1, 2 = both asserted.
  logic s_hist[$];
  logic r_hist[$];
  logic m_sf, m_rf;
  int   m_mode  = 0;
  logic m_setp  = 1'b0;
  logic m_rstp  = 1'b0;

  function automatic void model_reset();
    s_hist.delete();
    r_hist.delete();
    for (int k = 0; k < D + 2; k++) begin
      s_hist.push_back(1'b1);
      r_hist.push_back(1'b1);
    end
    m_sf   = 1'b1;
    m_rf   = 1'b1;
    m_mode = 0;
    m_setp = 1'b0;
    m_rstp = 1'b0;
  endfunction

  // The synchronised value seen at this edge is the input sampled two
  // edges ago. The filter flips when the last D of those all differ from it.
  function automatic logic window_all_differ(input logic hist[$], input logic f);
    for (int k = 1; k <= D; k++)
      if (hist[hist.size() - 1 - k] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int  new_mode;
      logic flip_s, flip_r;
      // latch rules on the filtered values present before this edge
      if (!m_sf && !m_rf)      new_mode = 2;
      else if (!m_sf)          new_mode = 1;
      else if (!m_rf)          new_mode = 0;
      else if (m_mode == 2)    new_mode = 0;
      else                     new_mode = m_mode;
      m_setp = (new_mode == 1) && (m_mode != 1);
      m_rstp = (new_mode == 0) && (m_mode != 0);
      m_mode = new_mode;
      // debounce
      flip_s = window_all_differ(s_hist, m_sf);
      flip_r = window_all_differ(r_hist, m_rf);
      if (flip_s) m_sf = ~m_sf;
      if (flip_r) m_rf = ~m_rf;
      // record this edge's sample
      s_hist.push_back(s_n);
      r_hist.push_back(r_n);
      if (s_hist.size() > D + 2) void'(s_hist.pop_front());
      if (r_hist.size() > D + 2) void'(r_hist.pop_front());
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [4:0] exp_q[$];
  logic       cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4:0] e;
      exp_q.push_back({m_mode != 0, m_mode != 1, m_setp, m_rstp, m_mode == 2});
      e = exp_q.pop_front();
      check("q",           q,           e[4]);
      check("qbar",        qbar,        e[3]);
      check("set_pulse",   set_pulse,   e[2]);
      check("reset_pulse", reset_pulse, e[1]);
      check("illegal",     illegal,     e[0]);
      if (set_pulse && reset_pulse) check("pulses_exclusive", 1'b1, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // reset block
    rst_n = 1'b0;
    s_n   = 1'b1;
    r_n   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", q, 1'b0);
    check("reset_qbar", qbar, 1'b1);
    check("reset_illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // idle with both released
    idle_negs(20);
    check("idle_q", q, 1'b0);
    check("idle_qbar", qbar, 1'b1);

    // set held: latch updates on edge 7
    s_n = 1'b0;
    wait_edges(6);
    check("set_e6_q", q, 1'b0);
    wait_edges(1);
    check("set_e7_q", q, 1'b1);
    check("set_e7_qbar", qbar, 1'b0);
    check("set_e7_pulse", set_pulse, 1'b1);
    wait_edges(1);
    check("set_e8_pulse", set_pulse, 1'b0);
    @(negedge clk);
    s_n = 1'b1;
    idle_negs(12);
    check("set_hold_q", q, 1'b1);

    // 3-cycle glitch on r_n is rejected
    r_n = 1'b0;
    idle_negs(3);
    r_n = 1'b1;
    idle_negs(12);
    check("glitch_q", q, 1'b1);

    // reset held
    r_n = 1'b0;
    wait_edges(6);
    check("rst_e6_q", q, 1'b1);
    wait_edges(1);
    check("rst_e7_q", q, 1'b0);
    check("rst_e7_pulse", reset_pulse, 1'b1);
    wait_edges(1);
    check("rst_e8_pulse", reset_pulse, 1'b0);
    @(negedge clk);
    r_n = 1'b1;
    idle_negs(12);

    // both asserted together -> forbidden
    s_n = 1'b0;
    r_n = 1'b0;
    wait_edges(6);
    check("forbid_e6_illegal", illegal, 1'b0);
    wait_edges(1);
    check("forbid_q", q, 1'b1);
    check("forbid_qbar", qbar, 1'b1);
    check("forbid_illegal", illegal, 1'b1);
    check("forbid_no_set", set_pulse, 1'b0);
    check("forbid_no_rst", reset_pulse, 1'b0);
    idle_negs(6);
    // release both together -> resolves to 0 with a reset strobe
    s_n = 1'b1;
    r_n = 1'b1;
    wait_edges(7);
    check("resolve_q", q, 1'b0);
    check("resolve_illegal", illegal, 1'b0);
    check("resolve_pulse", reset_pulse, 1'b1);

    // forbidden again, then release r_n only -> set
    @(negedge clk);
    s_n = 1'b0;
    r_n = 1'b0;
    idle_negs(12);
    check("forbid2_illegal", illegal, 1'b1);
    r_n = 1'b1;
    wait_edges(7);
    check("exit_set_q", q, 1'b1);
    check("exit_set_qbar", qbar, 1'b0);
    check("exit_set_illegal", illegal, 1'b0);
    check("exit_set_pulse", set_pulse, 1'b1);

    // asynchronous reset while set is still asserted
    idle_negs(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", q, 1'b0);
    check("async_qbar", qbar, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(6);
    check("post_rst_e6_q", q, 1'b0);
    wait_edges(1);
    check("post_rst_e7_q", q, 1'b1);
    check("post_rst_e7_pulse", set_pulse, 1'b1);

    // random phase: held input pairs of random length, occasional resets
    for (int seg = 0; seg < 600; seg++) begin
      @(negedge clk);
      s_n = 1'($urandom_range(0, 1));
      r_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      idle_negs($urandom_range(0, 9));
    end

    s_n = 1'b1;
    r_n = 1'b1;
    idle_negs(12);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
